mips_pipelined_top: RTL and testbench
=====================================

Name: mips_pipelined_top

Overview:
- Top level of a classic 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS pipelined processor.
- Contains the instruction memory, register file, ALU, data memory, forwarding/hazard logic and a 4-bit LED output register.
- The instruction memory is preloaded by simulation file load; the block has no bus interface.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (word index = PC[9:2]).
- DMEM_DEPTH, 256, data memory depth in 32-bit words (word index = ALU address[9:2]).
- LED_ADDR, 32'h0000_00FC, byte address whose store also updates led.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- led  output  4  LED register, written by a store to LED_ADDR.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - PC = 0.
  - All pipeline registers cleared to a NOP (all controls 0).
  - All 32 registers = 0; led = 0.
- Instruction memory:
  - Instance name instr_mem_inst; storage is an unpacked array named mem of IMEM_DEPTH x 32 bits, so it can be loaded hierarchically with $readmemh.
  - Combinational read; never written or reset by RTL.
  - Unloaded words (X) must not be relied on; tests end with a self-loop jump.
- Data memory: DMEM_DEPTH x 32; combinational read, synchronous write in MEM; not reset.
- Register file:
  - 32 x 32; $0 reads 0 and ignores writes.
  - Write on WB, readable in ID in the same cycle (internal write-through bypass).
- ISA, unsupported opcodes = NOP:
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type: lw 0x23, sw 0x2B, beq 0x04, addi 0x08 (sign-extended).
  - J-type: j 0x02.
- Arithmetic:
  - 32-bit two's complement, wrap-around; no overflow exceptions.
  - slt is a signed compare, result 1 or 0.
- PC advances by 4 each unstalled cycle.
- Forwarding (EX operands):
  - Priority: EX/MEM result, then MEM/WB result, then register file.
  - Only when the source register is nonzero and matches a writing destination.
- Load-use hazard: if the instruction in EX is lw and its rt equals rs/rt of the instruction in ID:
  - Stall PC and IF/ID one cycle.
  - Insert a bubble into ID/EX.
- beq:
  - Compare and target (PC+4 + signext(imm)<<2) resolved in EX.
  - If taken: PC <= target and flush IF/ID and ID/EX (2-cycle penalty). Not-taken: no penalty.
- j:
  - Resolved in ID: PC <= {PC+4[31:28], addr26, 2'b00}.
  - Flush IF/ID (1-cycle penalty).
- Simultaneous events: a taken branch in EX overrides a jump or stall in ID.
- sw to LED_ADDR:
  - Writes the data memory word.
  - On the same clock edge, led <= store data[3:0].
  - led holds its value otherwise.
- Latency: an instruction writes back 4 cycles after fetch, absent stalls or flushes.
- Reset asserted mid-execution immediately returns all state to reset values; fetch restarts at PC 0 after release.

Test Plan:
- Reset and LED write:
  - Stimulus: hold rst_n=0 for 1 cycle, release, run program addi $1,$0,5; sw $1,0xFC($0); j self.
  - Response: led=0 during reset; led=4'h5 after the sw's MEM stage; stays 5.
- ALU forwarding:
  - Stimulus: addi $2,$0,7; addi $3,$0,3; sub $4,$2,$3; and $5,$4,$2; or $6,$4,$3; slt $7,$3,$2; sw $4,0xFC($0).
  - Response: $4=4, $5=4, $6=7, $7=1; led=4.
- Load-use stall:
  - Stimulus: addi $1,$0,9; sw $1,0($0); lw $2,0($0); add $3,$2,$2; sw $3,0xFC($0).
  - Response: one bubble inserted; $3=18; led=4'h2.
- Branch:
  - Stimulus: beq $0,$0,+2 followed by two addi $5 instructions that must be flushed, then sw to led.
  - Response: $5 stays 0. A not-taken beq ($1!=$0) executes the following instruction with no penalty.
- Jump and loop:
  - Stimulus: count loop with addi/beq/j decrementing from 10 to 0, storing the counter to LED_ADDR each iteration.
  - Response: led ends at 0; PC parks on the final self-loop.
- $0 and wrap-around:
  - Stimulus: addi $0,$0,5 -> $0 still reads 0.
  - Stimulus: addi $1,$0,-1; addi $1,$1,1 -> $1=0.
  - Stimulus: assert rst_n low mid-program.
  - Response to reset: led=0 and registers cleared immediately.

Source files
------------

// File: rtl/mips_pipelined_top.sv
// mips_pipelined_top: classic 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset pipeline.
//
// Ports:
//   clk   - single system clock; all state updates on the rising edge
//   rst_n - asynchronous active-low reset (PC, pipeline registers, register file, led)
//   led   - 4-bit LED register, loaded with store data[3:0] by a sw to LED_ADDR
//
// Supported instructions: add sub and or slt (R-type), lw sw beq addi, j.
// Any other encoding travels down the pipe as a NOP.
// The instruction memory (instr_mem_inst.mem) is loaded from outside the RTL.
module mips_pipelined_top #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] LED_ADDR   = 32'h0000_00FC
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] led
);

  localparam int unsigned ImemAw = $clog2(IMEM_DEPTH);
  localparam int unsigned DmemAw = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_res;
    logic [31:0] wdata;
    logic [4:0]  dst;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_res;
    logic [31:0] rdata;
    logic [4:0]  dst;
  } memwb_t;

  // Pipeline state
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;
  logic [3:0]  led_q, led_d;
  logic [31:0] regs_q [32];

  // IF
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  // ID
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, id_rd1, id_rd2;
  logic        id_jump;
  logic        id_stall;
  idex_t       id_dec;

  // EX
  logic [31:0] ex_a, ex_fb, ex_b, ex_res, ex_target;
  logic        ex_taken;

  // MEM / WB
  logic [DmemAw-1:0] dmem_idx;
  logic [31:0]       dmem_rdata;
  logic              led_we;
  logic [31:0]       wb_data;

  // ---------------------------------------------------------------------------
  // IF: combinational instruction fetch
  // ---------------------------------------------------------------------------
  if (1) begin : instr_mem_inst
    logic [31:0] mem [IMEM_DEPTH];
    assign if_instr = mem[pc_q[ImemAw+1:2]];
  end

  assign if_pc4 = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // ID: decode, register read, hazard detection
  // ---------------------------------------------------------------------------
  assign id_op    = ifid_q.instr[31:26];
  assign id_rs    = ifid_q.instr[25:21];
  assign id_rt    = ifid_q.instr[20:16];
  assign id_rd    = ifid_q.instr[15:11];
  assign id_funct = ifid_q.instr[5:0];
  assign id_imm   = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};

  // Write-through: a WB write is visible to the ID read in the same cycle.
  always_comb begin
    id_rd1 = regs_q[id_rs];
    if (id_rs == 5'd0) begin
      id_rd1 = '0;
    end else if (memwb_q.reg_write && (memwb_q.dst == id_rs)) begin
      id_rd1 = wb_data;
    end
    id_rd2 = regs_q[id_rt];
    if (id_rt == 5'd0) begin
      id_rd2 = '0;
    end else if (memwb_q.reg_write && (memwb_q.dst == id_rt)) begin
      id_rd2 = wb_data;
    end
  end

  always_comb begin
    id_dec        = '0;
    id_jump       = 1'b0;
    id_dec.alu_op = AluAdd;
    id_dec.rs     = id_rs;
    id_dec.rt     = id_rt;
    id_dec.rd1    = id_rd1;
    id_dec.rd2    = id_rd2;
    id_dec.imm    = id_imm;
    id_dec.pc4    = ifid_q.pc4;
    case (id_op)
      OpRtype: begin
        id_dec.reg_write = 1'b1;
        id_dec.dst       = id_rd;
        case (id_funct)
          FnAdd:   id_dec.alu_op = AluAdd;
          FnSub:   id_dec.alu_op = AluSub;
          FnAnd:   id_dec.alu_op = AluAnd;
          FnOr:    id_dec.alu_op = AluOr;
          FnSlt:   id_dec.alu_op = AluSlt;
          default: id_dec.reg_write = 1'b0;
        endcase
      end
      OpLw: begin
        id_dec.reg_write  = 1'b1;
        id_dec.mem_to_reg = 1'b1;
        id_dec.mem_read   = 1'b1;
        id_dec.alu_src    = 1'b1;
        id_dec.dst        = id_rt;
      end
      OpSw: begin
        id_dec.mem_write = 1'b1;
        id_dec.alu_src   = 1'b1;
      end
      OpBeq: begin
        id_dec.branch = 1'b1;
        id_dec.alu_op = AluSub;
      end
      OpAddi: begin
        id_dec.reg_write = 1'b1;
        id_dec.alu_src   = 1'b1;
        id_dec.dst       = id_rt;
      end
      OpJ: id_jump = 1'b1;
      default: ;
    endcase
  end

  assign id_stall = idex_q.mem_read && ((idex_q.rt == id_rs) || (idex_q.rt == id_rt));

  // ---------------------------------------------------------------------------
  // EX: forwarding, ALU, branch resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_a = idex_q.rd1;
    if (exmem_q.reg_write && (exmem_q.dst != 5'd0) && (exmem_q.dst == idex_q.rs)) begin
      ex_a = exmem_q.alu_res;
    end else if (memwb_q.reg_write && (memwb_q.dst != 5'd0) && (memwb_q.dst == idex_q.rs)) begin
      ex_a = wb_data;
    end
    ex_fb = idex_q.rd2;
    if (exmem_q.reg_write && (exmem_q.dst != 5'd0) && (exmem_q.dst == idex_q.rt)) begin
      ex_fb = exmem_q.alu_res;
    end else if (memwb_q.reg_write && (memwb_q.dst != 5'd0) && (memwb_q.dst == idex_q.rt)) begin
      ex_fb = wb_data;
    end
  end

  assign ex_b = idex_q.alu_src ? idex_q.imm : ex_fb;

  always_comb begin
    case (idex_q.alu_op)
      AluSub:  ex_res = ex_a - ex_b;
      AluAnd:  ex_res = ex_a & ex_b;
      AluOr:   ex_res = ex_a | ex_b;
      AluSlt:  ex_res = {31'd0, ($signed(ex_a) < $signed(ex_b))};
      default: ex_res = ex_a + ex_b;
    endcase
  end

  assign ex_taken  = idex_q.branch && (ex_a == ex_fb);
  assign ex_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};

  // ---------------------------------------------------------------------------
  // MEM: data memory and LED register
  // ---------------------------------------------------------------------------
  logic [31:0] dmem [DMEM_DEPTH];

  assign dmem_idx   = exmem_q.alu_res[DmemAw+1:2];
  assign dmem_rdata = dmem[dmem_idx];
  assign led_we     = exmem_q.mem_write && (exmem_q.alu_res == LED_ADDR);
  assign led_d      = led_we ? exmem_q.wdata[3:0] : led_q;
  assign led        = led_q;

  always_ff @(posedge clk) begin
    if (exmem_q.mem_write) begin
      dmem[dmem_idx] <= exmem_q.wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // WB
  // ---------------------------------------------------------------------------
  assign wb_data = memwb_q.mem_to_reg ? memwb_q.rdata : memwb_q.alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (memwb_q.reg_write && (memwb_q.dst != 5'd0)) begin
      regs_q[memwb_q.dst] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: taken branch beats load-use stall, which beats jump
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d         = if_pc4;
    ifid_d.instr = if_instr;
    ifid_d.pc4   = if_pc4;
    idex_d       = id_dec;
    if (ex_taken) begin
      pc_d   = ex_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (id_stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end else if (id_jump) begin
      pc_d   = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};
      ifid_d = '0;
    end

    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.alu_res    = ex_res;
    exmem_d.wdata      = ex_fb;
    exmem_d.dst        = idex_q.dst;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.alu_res    = exmem_q.alu_res;
    memwb_d.rdata      = dmem_rdata;
    memwb_d.dst        = exmem_q.dst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      led_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: tb/tb_mips_pipelined_top.sv
// Testbench for mips_pipelined_top: loads directed programs into instruction memory,
// predicts every LED update (value and clock edge after reset release) in a
// scoreboard queue, and a monitor pops/compares whenever led changes.
module tb_mips_pipelined_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] led;

  mips_pipelined_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .led   (led)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;

  typedef struct {
    logic [3:0]  val;
    int unsigned cyc;
    string       name;
  } led_exp_t;

  led_exp_t    exp_q[$];
  int          checks;
  int          failures;
  int unsigned cyc;
  logic [3:0]  led_prev;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int addr);
    return {OpJ, 26'(addr)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_led(input logic [3:0] val, input int unsigned at, input string name);
    led_exp_t e;
    e.val  = val;
    e.cyc  = at;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_pending(input string name);
    check({name, "_pending_led_events"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.instr_mem_inst.mem[i] = 32'h0;
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.instr_mem_inst.mem[idx] = w;
  endtask

  task automatic enter_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_rst_led"}, 32'(led), 32'd0);
    check({name, "_rst_pc"}, dut.pc_q, 32'd0);
  endtask

  task automatic release_run(input int n);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Count loop: stores 10..0 to the LED, one store every 5 cycles.
  task automatic load_loop();
    clear_imem();
    put(0, enc_i(OpAddi, 0, 1, 10));
    put(1, enc_i(OpSw, 0, 1, 16'hFC));
    put(2, enc_i(OpBeq, 1, 0, 2));
    put(3, enc_i(OpAddi, 1, 1, -1));
    put(4, enc_j(1));
    put(5, enc_j(5));
  endtask

  // Clock edges counted from reset release; edge 1 latches instruction 0 into IF/ID.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin : monitor
    led_exp_t e;
    if (!rst_n) begin
      led_prev = 4'h0;
    end else if (led !== led_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_led_change", 32'(led), 32'(led_prev));
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_val"}, 32'(led), 32'(e.val));
        check({e.name, "_cyc"}, cyc, e.cyc);
      end
      led_prev = led;
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    led_prev = 4'h0;
    #1 rst_n = 1'b0;

    // P1: reset and LED write
    enter_reset("p1");
    clear_imem();
    put(0, enc_i(OpAddi, 0, 1, 5));
    put(1, enc_i(OpSw, 0, 1, 16'hFC));
    put(2, enc_j(2));
    expect_led(4'h5, 5, "p1_led");
    release_run(40);
    check("p1_led_hold", 32'(led), 32'h5);
    check("p1_r1", dut.regs_q[1], 32'd5);
    check_pending("p1");

    // P2: ALU forwarding
    enter_reset("p2");
    clear_imem();
    put(0, enc_i(OpAddi, 0, 2, 7));
    put(1, enc_i(OpAddi, 0, 3, 3));
    put(2, enc_r(2, 3, 4, FnSub));
    put(3, enc_r(4, 2, 5, FnAnd));
    put(4, enc_r(4, 3, 6, FnOr));
    put(5, enc_r(3, 2, 7, FnSlt));
    put(6, enc_i(OpSw, 0, 4, 16'hFC));
    put(7, enc_j(7));
    expect_led(4'h4, 10, "p2_led");
    release_run(40);
    check("p2_r4", dut.regs_q[4], 32'd4);
    check("p2_r5", dut.regs_q[5], 32'd4);
    check("p2_r6", dut.regs_q[6], 32'd7);
    check("p2_r7", dut.regs_q[7], 32'd1);
    check_pending("p2");

    // P3: load-use stall costs exactly one cycle
    enter_reset("p3");
    check("p3_rst_r4", dut.regs_q[4], 32'd0);
    clear_imem();
    put(0, enc_i(OpAddi, 0, 1, 9));
    put(1, enc_i(OpSw, 0, 1, 0));
    put(2, enc_i(OpLw, 0, 2, 0));
    put(3, enc_r(2, 2, 3, FnAdd));
    put(4, enc_i(OpSw, 0, 3, 16'hFC));
    put(5, enc_j(5));
    expect_led(4'h2, 9, "p3_led");
    release_run(40);
    check("p3_r2", dut.regs_q[2], 32'd9);
    check("p3_r3", dut.regs_q[3], 32'd18);
    check_pending("p3");

    // P4: taken beq flushes two slots, not-taken beq costs nothing
    enter_reset("p4");
    clear_imem();
    put(0, enc_i(OpAddi, 0, 1, 1));
    put(1, enc_i(OpBeq, 0, 0, 2));
    put(2, enc_i(OpAddi, 0, 5, 1));
    put(3, enc_i(OpAddi, 0, 5, 2));
    put(4, enc_i(OpBeq, 1, 0, 1));
    put(5, enc_i(OpAddi, 0, 6, 3));
    put(6, enc_i(OpSw, 0, 6, 16'hFC));
    put(7, enc_j(7));
    expect_led(4'h3, 10, "p4_led");
    release_run(40);
    check("p4_r5_flushed", dut.regs_q[5], 32'd0);
    check("p4_r6", dut.regs_q[6], 32'd3);
    check_pending("p4");

    // P5: count loop 10..0
    enter_reset("p5");
    load_loop();
    for (int v = 10; v >= 0; v--) begin
      expect_led(4'(v), 32'(5 + 5 * (10 - v)), $sformatf("p5_led%0d", v));
    end
    release_run(100);
    check("p5_r1", dut.regs_q[1], 32'd0);
    check("p5_led_final", 32'(led), 32'd0);
    check_pending("p5");

    // P6: $0 is immutable and never forwarded; addi wraps
    enter_reset("p6");
    clear_imem();
    put(0, enc_i(OpAddi, 0, 0, 5));
    put(1, enc_i(OpAddi, 0, 2, 6));
    put(2, enc_r(0, 2, 3, FnOr));
    put(3, enc_i(OpAddi, 0, 1, -1));
    put(4, enc_i(OpAddi, 1, 1, 1));
    put(5, enc_i(OpSw, 0, 3, 16'hFC));
    put(6, enc_j(6));
    expect_led(4'h6, 9, "p6_led");
    release_run(40);
    check("p6_r0", dut.regs_q[0], 32'd0);
    check("p6_r3", dut.regs_q[3], 32'd6);
    check("p6_r1_wrap", dut.regs_q[1], 32'd0);
    check_pending("p6");

    // P7: reset mid-loop, then the loop restarts from PC 0
    enter_reset("p7");
    load_loop();
    for (int v = 10; v >= 6; v--) begin
      expect_led(4'(v), 32'(5 + 5 * (10 - v)), $sformatf("p7a_led%0d", v));
    end
    release_run(27);
    check("p7_mid_r1", dut.regs_q[1], 32'd6);
    enter_reset("p7_mid");
    check("p7_mid_rst_r1", dut.regs_q[1], 32'd0);
    check_pending("p7a");
    for (int v = 10; v >= 0; v--) begin
      expect_led(4'(v), 32'(5 + 5 * (10 - v)), $sformatf("p7b_led%0d", v));
    end
    release_run(100);
    check("p7_led_final", 32'(led), 32'd0);
    check_pending("p7b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
